// File: rtl/tone_period_meter_if.sv
// Bus bundle for tone_period_meter: raw tone pin in, measurement results and LEDs out.
// master = meter side, slave = pin driver / result consumer side.
interface tone_period_meter_if #(
    parameter int unsigned PERIOD_W = 20
);
    logic                tone_in;
    logic [PERIOD_W-1:0] period;
    logic                period_valid;
    logic                tone_present;
    logic [5:0]          led;

    modport master (
        input  tone_in,
        output period,
        output period_valid,
        output tone_present,
        output led
    );

    modport slave (
        output tone_in,
        input  period,
        input  period_valid,
        input  tone_present,
        input  led
    );
endinterface

// File: rtl/tone_period_meter.sv
// Measures rising-edge to rising-edge period of an asynchronous tone pin in clk cycles.
// Optional macro PERIOD_AVG_EN reports the mean of the last 4 accepted periods instead.
module tone_period_meter #(
    parameter int unsigned CLK_HZ         = 27000000,
    parameter int unsigned PERIOD_W       = 20,
    parameter int unsigned MIN_PERIOD     = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                rst_n,
    tone_period_meter_if.master bus
);

    localparam logic [PERIOD_W-1:0] CNT_MIN     = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] CNT_TIMEOUT = PERIOD_W'(TIMEOUT_CYCLES);
    localparam logic [PERIOD_W-1:0] CNT_ONE     = PERIOD_W'(1);

    // Reject parameter sets where the counter could wrap or the LED slice does not fit.
    if ((64'(TIMEOUT_CYCLES) >= (64'(1) << PERIOD_W)) || (TIMEOUT_CYCLES < MIN_PERIOD) ||
        (CLK_HZ == 0) || (PERIOD_W < 5)) begin : g_bad_cfg
        $error("tone_period_meter: inconsistent parameters");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_sync3;
    logic                w_rise;
    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] w_cnt_nxt;
    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] w_period_nxt;
    logic                r_valid;
    logic                w_valid_nxt;
    logic                r_tp;
    logic                w_tp_nxt;
    logic [5:0]          r_led;

`ifdef PERIOD_AVG_EN
    localparam int unsigned SUM_W = PERIOD_W + 2;

    logic [PERIOD_W-1:0] r_hist     [3];
    logic [PERIOD_W-1:0] w_hist_nxt [3];
    logic [2:0]          r_hist_n;
    logic [2:0]          w_hist_n_nxt;
    logic [SUM_W-1:0]    w_sum;
    logic [PERIOD_W-1:0] w_avg;

    assign w_sum = SUM_W'(r_hist[0]) + SUM_W'(r_hist[1]) + SUM_W'(r_hist[2]) + SUM_W'(r_cnt);
    assign w_avg = PERIOD_W'(w_sum >> 2);
`endif

    // Two-flop synchronizer plus a delay flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= bus.tone_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_sync3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A rise on the timeout cycle wins over the timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_rise) w_state_nxt = S_COUNT;
            S_COUNT: if (!w_rise && (r_cnt == CNT_TIMEOUT)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_period_nxt = r_period;
        w_valid_nxt  = 1'b0;
        w_tp_nxt     = r_tp;
`ifdef PERIOD_AVG_EN
        w_hist_n_nxt = r_hist_n;
        for (int i = 0; i < 3; i++) begin
            w_hist_nxt[i] = r_hist[i];
        end
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = w_rise ? CNT_ONE : '0;
            end
            S_COUNT: begin
                if (w_rise) begin
                    w_cnt_nxt = CNT_ONE;
                    // Intervals shorter than MIN_PERIOD are glitches: restart from this edge only.
                    if ((r_cnt >= CNT_MIN) && (r_cnt <= CNT_TIMEOUT)) begin
`ifdef PERIOD_AVG_EN
                        w_hist_nxt[2] = r_hist[1];
                        w_hist_nxt[1] = r_hist[0];
                        w_hist_nxt[0] = r_cnt;
                        w_hist_n_nxt  = (r_hist_n >= 3'd4) ? 3'd4 : r_hist_n + 3'd1;
                        if (r_hist_n >= 3'd3) begin
                            w_period_nxt = w_avg;
                            w_valid_nxt  = 1'b1;
                            w_tp_nxt     = 1'b1;
                        end
`else
                        w_period_nxt = r_cnt;
                        w_valid_nxt  = 1'b1;
                        w_tp_nxt     = 1'b1;
`endif
                    end
                end else if (r_cnt == CNT_TIMEOUT) begin
                    w_cnt_nxt = '0;
                    w_tp_nxt  = 1'b0;
`ifdef PERIOD_AVG_EN
                    w_hist_n_nxt = 3'd0;
                    for (int i = 0; i < 3; i++) begin
                        w_hist_nxt[i] = '0;
                    end
`endif
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_cnt_nxt = '0;
            end
        endcase
    end

    // LEDs follow the registered flag and period one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_period <= '0;
            r_valid  <= 1'b0;
            r_tp     <= 1'b0;
            r_led    <= 6'b111111;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_period <= w_period_nxt;
            r_valid  <= w_valid_nxt;
            r_tp     <= w_tp_nxt;
            r_led    <= {~r_tp, ~r_period[PERIOD_W-1 -: 5]};
        end
    end

`ifdef PERIOD_AVG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist_n <= 3'd0;
            for (int i = 0; i < 3; i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            r_hist_n <= w_hist_n_nxt;
            for (int i = 0; i < 3; i++) begin
                r_hist[i] <= w_hist_nxt[i];
            end
        end
    end
`endif

    assign bus.period       = r_period;
    assign bus.period_valid = r_valid;
    assign bus.tone_present = r_tp;
    assign bus.led          = r_led;

endmodule
